// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_t;

  localparam int NB_DEFAULT = 8;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// The partial remainder is shifted left with the next dividend bit appended,
// then the divisor magnitude is trial-subtracted; the quotient bit is set when
// the subtraction does not go negative, otherwise the shifted value is restored.
module div_step #(
  parameter int nb = 8
) (
  input  logic [nb:0]   i_rem,
  input  logic          i_bit,
  input  logic [nb-1:0] i_dsr,
  output logic [nb:0]   o_rem,
  output logic          o_q
);

  logic [nb:0] w_shifted;
  logic [nb:0] w_diff;

  assign w_shifted = {i_rem[nb-1:0], i_bit};
  assign w_diff    = w_shifted - {1'b0, i_dsr};

  // Trial subtract: the full incoming remainder (including its top bit) decides
  // whether the shifted value reaches the divisor magnitude.
  always_comb begin
    o_q   = ({i_rem, i_bit} >= {2'b00, i_dsr});
    o_rem = o_q ? w_diff : w_shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider. Truncating quotient and dividend-signed
// remainder, one quotient bit per clock, start/ready handshake.
//
// Handshake: ready is high exactly when the FSM is in IDLE and Quotient,
// Remainder and div_by_zero hold the last completed result. start is sampled
// on every rising edge in any state; a start in DIVIDE or FIXUP aborts the
// in-flight operation and loads the new operands. A and B are sampled only on
// the start edge. A zero divisor completes on the start edge itself, so ready
// never drops for it.
module seq_divider
  import divider_pkg::*;
#(
  parameter int nb = NB_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [nb-1:0] A,
  input  logic [nb-1:0] B,
  output logic [nb-1:0] Quotient,
  output logic [nb-1:0] Remainder,
  output logic          ready,
  output logic          div_by_zero,
  output state_t        dbg_state
);

  localparam int CW = $clog2(nb + 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [nb:0]   r_rem;
  logic [nb-1:0] r_dvd;
  logic [nb-1:0] r_dsr;
  logic          r_sign_q;
  logic          r_sign_r;
  logic [nb-1:0] r_quot;
  logic [nb-1:0] r_remo;
  logic          r_dbz;

  logic [nb-1:0] w_a_mag;
  logic [nb-1:0] w_b_mag;
  logic          w_b_zero;
  logic [nb:0]   w_step_rem;
  logic          w_step_q;
  logic [nb-1:0] w_q_fix;
  logic [nb-1:0] w_r_fix;

  // Magnitudes fit nb-bit unsigned, including |-2^(nb-1)| = 2^(nb-1).
  assign w_a_mag  = A[nb-1] ? (-A) : A;
  assign w_b_mag  = B[nb-1] ? (-B) : B;
  assign w_b_zero = (B == '0);

  // After nb steps r_dvd holds the quotient magnitude and r_rem the remainder magnitude.
  assign w_q_fix = r_sign_q ? (-r_dvd) : r_dvd;
  assign w_r_fix = r_sign_r ? (-r_rem[nb-1:0]) : r_rem[nb-1:0];

  div_step #(.nb(nb)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[nb-1]),
    .i_dsr (r_dsr),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; start overrides whatever the FSM was doing.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = IDLE;
      DIVIDE:  if (r_cnt == CW'(1)) w_next_state = FIXUP;
      FIXUP:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (start) w_next_state = w_b_zero ? IDLE : DIVIDE;
  end

  // Datapath: operand load, iteration registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_quot   <= '0;
      r_remo   <= '0;
      r_dbz    <= 1'b0;
    end else if (start) begin
      r_cnt    <= CW'(nb);
      r_rem    <= '0;
      r_dvd    <= w_a_mag;
      r_dsr    <= w_b_mag;
      r_sign_q <= A[nb-1] ^ B[nb-1];
      r_sign_r <= A[nb-1];
      if (w_b_zero) begin
        r_dbz  <= 1'b1;
        r_quot <= '1;
        r_remo <= A;
      end else begin
        r_dbz  <= 1'b0;
      end
    end else begin
      case (r_state)
        DIVIDE: begin
          r_rem <= w_step_rem;
          r_dvd <= {r_dvd[nb-2:0], w_step_q};
          r_cnt <= r_cnt - CW'(1);
        end
        FIXUP: begin
          r_quot <= w_q_fix;
          r_remo <= w_r_fix;
        end
        default: ;
      endcase
    end
  end

  assign Quotient    = r_quot;
  assign Remainder   = r_remo;
  assign div_by_zero = r_dbz;
  assign ready       = (r_state == IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (nb = 8): directed sign/boundary cases,
// divide-by-zero, restart, mid-operation reset and random back-to-back vectors.
module tb_seq_divider;
  import divider_pkg::*;

  localparam int NB = 8;
  localparam int LAT = NB + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] A = '0;
  logic [NB-1:0] B = '0;
  logic [NB-1:0] quotient;
  logic [NB-1:0] remainder;
  logic          ready;
  logic          dbz;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  // {div_by_zero, quotient, remainder}
  logic [2*NB:0] exp_q[$];
  logic [NB-1:0] hold_q = '0;
  logic [NB-1:0] hold_r = '0;

  seq_divider #(.nb(NB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Quotient    (quotient),
    .Remainder   (remainder),
    .ready       (ready),
    .div_by_zero (dbz),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model using native signed int division (truncates toward zero).
  function automatic logic [2*NB:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int sa, sb;
    logic [31:0] q, r;
    logic dz;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q  = 32'hFFFF_FFFF;
      r  = sa;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      dz = 1'b0;
    end
    return {dz, q[NB-1:0], r[NB-1:0]};
  endfunction

  // Driver: called at a negedge; presents one start pulse, optionally records the expectation.
  task automatic drive_start(input logic [NB-1:0] a, input logic [NB-1:0] b, input bit expect_it);
    A = a;
    B = b;
    start = 1'b1;
    if (expect_it) exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    A = NB'($urandom);
    B = NB'($urandom);
  endtask

  // Waits (bounded) for ready, checking outputs hold meanwhile, then scores the result.
  task automatic wait_result(input string tag, input int exp_lat);
    int cnt;
    logic [2*NB:0] e;
    cnt = 0;
    while (!ready && cnt < 50) begin
      check({tag, "_hold_q"}, quotient, hold_q);
      check({tag, "_hold_r"}, remainder, hold_r);
      cnt++;
      @(negedge clk);
    end
    check({tag, "_lat"}, cnt, exp_lat);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_q"}, quotient, e[2*NB-1:NB]);
    check({tag, "_r"}, remainder, e[NB-1:0]);
    check({tag, "_dbz"}, dbz, e[2*NB]);
    check({tag, "_rdy"}, ready, 1);
    hold_q = e[2*NB-1:NB];
    hold_r = e[NB-1:0];
  endtask

  task automatic do_div(input string tag, input logic [NB-1:0] a, input logic [NB-1:0] b);
    drive_start(a, b, 1'b1);
    wait_result(tag, (b == '0) ? 0 : LAT);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_rdy", ready, 1);
    check("rst_dbz", dbz, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_div("p_p", 8'd100, 8'd7);
    do_div("n_p", 8'h9C, 8'd7);
    do_div("p_n", 8'd100, 8'hF9);
    do_div("n_n", 8'h9C, 8'hF9);
    do_div("min_m1", 8'h80, 8'hFF);
    do_div("min_p1", 8'h80, 8'h01);
    do_div("zero_a", 8'h00, 8'd5);
    do_div("dz", 8'd5, 8'd0);
    check("dz_state", dbg_state, IDLE);
    do_div("after_dz", 8'd9, 8'd3);

    // Restart mid-division: only the second operation may produce a result
    drive_start(8'd100, 8'd7, 1'b0);
    repeat (3) begin
      check("rs_hold_q", quotient, hold_q);
      check("rs_rdy", ready, 0);
      @(negedge clk);
    end
    drive_start(8'd50, 8'd5, 1'b1);
    wait_result("restart", LAT);
    check("restart_q10", quotient, 10);

    // Reset mid-operation
    drive_start(8'd77, 8'd3, 1'b0);
    repeat (4) @(negedge clk);
    check("mr_busy", ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_q", quotient, 0);
    check("mr_r", remainder, 0);
    check("mr_rdy", ready, 1);
    check("mr_dbz", dbz, 0);
    check("mr_state", dbg_state, IDLE);
    hold_q = '0;
    hold_r = '0;
    @(negedge clk);

    // Random back-to-back vectors (start issued as soon as ready reads 1)
    for (int i = 0; i < 2000; i++) begin
      logic [NB-1:0] a, b;
      a = NB'($urandom);
      b = NB'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: a = 8'h80;
        2: b = 8'hFF;
        3: b = NB'($urandom_range(1, 3));
        default: ;
      endcase
      do_div("rnd", a, b);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
